// File: rtl/clock_display_driver.sv
// HH:MM driver for a 4-digit common-anode multiplexed 7-segment display, with an alarm ringing FSM.
// Build macro COLON_BLINK_EN: when defined, the colon flashes at the blink rate outside RINGING.
module clock_display_driver #(
    parameter int SCAN_DIV      = 50000,
    parameter int BLINK_DIV     = 25000000,
    parameter int ALARM_TIMEOUT = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] minutes,
    input  logic [5:0] hours,
    input  logic       alarm_trigger,
    input  logic       alarm_ack,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       buzzer
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TO_W    = $clog2(ALARM_TIMEOUT + 1);

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        ACKED   = 2'd2
    } alarm_state_t;

    alarm_state_t state, next_state;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         digit_idx;
    logic [6:0]         min_lat;
    logic [5:0]         hr_lat;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [TO_W-1:0]    to_cnt;
    logic               trig_d;

    logic scan_tc, blink_tc, trig_rise, enter_ring, timed_out;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign scan_tc    = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign blink_tc   = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
    assign trig_rise  = alarm_trigger & ~trig_d;
    assign timed_out  = (to_cnt == TO_W'(ALARM_TIMEOUT));
    assign enter_ring = (state == IDLE) && (next_state == RINGING);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (trig_rise) next_state = RINGING;
            RINGING: if (alarm_ack || timed_out) next_state = ACKED;
            ACKED:   if (!alarm_trigger) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            trig_d    <= 1'b1;   // a trigger still high after reset must not ring
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
            min_lat   <= '0;
            hr_lat    <= '0;
        end else begin
            state  <= next_state;
            trig_d <= alarm_trigger;
            if (scan_tc) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
                if (digit_idx == 2'd3) begin
                    min_lat <= minutes;
                    hr_lat  <= hours;
                end
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || enter_ring) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_tc) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || enter_ring)
            to_cnt <= '0;
        else if (state == RINGING && blink_tc && !timed_out)
            to_cnt <= to_cnt + TO_W'(1);
    end

    logic [3:0] min_units, min_tens, hr_units, hr_tens;
    logic       min_bad, hr_bad, dark, colon_on;
    logic [6:0] seg_d;
    logic [3:0] an_d;

    assign min_units = 4'(min_lat % 7'd10);
    assign min_tens  = 4'(min_lat / 7'd10);
    assign hr_units  = 4'(hr_lat % 6'd10);
    assign hr_tens   = 4'(hr_lat / 6'd10);
    assign min_bad   = (min_lat >= 7'd60);
    assign hr_bad    = (hr_lat >= 6'd24);
    assign dark      = (state == RINGING) && !blink_phase;

    always_comb begin
        seg_d = SEG_BLANK;
        case (digit_idx)
            2'd0: seg_d = min_bad ? SEG_DASH : seg_code(min_units);
            2'd1: seg_d = min_bad ? SEG_DASH : seg_code(min_tens);
            2'd2: seg_d = hr_bad  ? SEG_DASH : seg_code(hr_units);
            2'd3: seg_d = hr_bad  ? SEG_DASH : (hr_lat < 6'd10) ? SEG_BLANK : seg_code(hr_tens);
            default: seg_d = SEG_BLANK;
        endcase
    end

    assign an_d = dark ? 4'hF : ~(4'b0001 << digit_idx);

`ifdef COLON_BLINK_EN
    // Phase gating also covers the RINGING dark phase, so both states share one expression.
    assign colon_on = (digit_idx == 2'd2) && blink_phase;
`else
    assign colon_on = (digit_idx == 2'd2) && !dark;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            seg    <= SEG_BLANK;
            an     <= 4'hF;
            dp     <= 1'b1;
            buzzer <= 1'b0;
        end else begin
            seg    <= seg_d;
            an     <= an_d;
            dp     <= ~colon_on;
            buzzer <= (state == RINGING) && blink_phase;
        end
    end

endmodule

// File: tb/tb_clock_display_driver.sv
// Scoreboard bench for clock_display_driver: an event-level reference model queues the expected
// outputs of every clock edge and an independent monitor compares them against the DUT.
module tb_clock_display_driver;

    localparam int SCAN_DIV      = 4;
    localparam int BLINK_DIV     = 8;
    localparam int ALARM_TIMEOUT = 4;
    localparam int FRAME         = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] minutes;
    logic [5:0] hours;
    logic       alarm_trigger;
    logic       alarm_ack;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       buzzer;

    clock_display_driver #(
        .SCAN_DIV      (SCAN_DIV),
        .BLINK_DIV     (BLINK_DIV),
        .ALARM_TIMEOUT (ALARM_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .minutes       (minutes),
        .hours         (hours),
        .alarm_trigger (alarm_trigger),
        .alarm_ack     (alarm_ack),
        .seg           (seg),
        .an            (an),
        .dp            (dp),
        .buzzer        (buzzer)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef enum { M_IDLE, M_RING, M_ACKED } mode_t;

    logic [12:0] exp_q[$];
    logic [6:0]  seg_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Model state: edges since reset release, alarm mode, and the edge the blink phase restarted at.
    int    k;
    mode_t mode;
    int    ring_start;
    int    blink_base;
    int    lat_min;
    int    lat_hr;
    bit    trig_prev;

    function automatic logic [6:0] digit_seg(int idx, int mn, int hr);
        case (idx)
            0:       return (mn >= 60) ? 7'h3F : seg_tab[mn % 10];
            1:       return (mn >= 60) ? 7'h3F : seg_tab[mn / 10];
            2:       return (hr >= 24) ? 7'h3F : seg_tab[hr % 10];
            default: return (hr >= 24) ? 7'h3F : (hr < 10) ? 7'h7F : seg_tab[hr / 10];
        endcase
    endfunction

    task automatic model_step();
        int         idx;
        bit         ringing, phase, dark, colon;
        logic [3:0] e_an;
        if (rst) begin
            k = 0; mode = M_IDLE; ring_start = 0; blink_base = 0;
            lat_min = 0; lat_hr = 0; trig_prev = 1'b1;
            exp_q.push_back({7'h7F, 4'hF, 1'b1, 1'b0});
            return;
        end
        idx     = (k / SCAN_DIV) % 4;
        ringing = (mode == M_RING);
        phase   = (((k - blink_base) / BLINK_DIV) % 2) == 0;
        dark    = ringing && !phase;
        e_an    = dark ? 4'hF : 4'hF ^ 4'(1 << idx);
        colon   = (idx == 2) && !dark;
`ifdef COLON_BLINK_EN
        colon   = colon && phase;
`endif
        exp_q.push_back({digit_seg(idx, lat_min, lat_hr), e_an, !colon, ringing && phase});

        // Apply this edge: alarm decisions use the inputs present at the edge.
        case (mode)
            M_IDLE:
                if (alarm_trigger && !trig_prev) begin
                    mode = M_RING; ring_start = k + 1; blink_base = k + 1;
                end
            M_RING:
                if (alarm_ack || ((k - ring_start) / BLINK_DIV) >= ALARM_TIMEOUT) mode = M_ACKED;
            default:
                if (!alarm_trigger) mode = M_IDLE;
        endcase
        trig_prev = alarm_trigger;
        k++;
        if (k % FRAME == 0) begin
            lat_min = int'(minutes);
            lat_hr  = int'(hours);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cycle++;
        model_step();
    end

    task automatic check(string name, logic [12:0] got, logic [12:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got seg=%h an=%h dp=%b buzzer=%b expected seg=%h an=%h dp=%b buzzer=%b",
                     name, cycle, got[12:6], got[5:2], got[1], got[0],
                     want[12:6], want[5:2], want[1], want[0]);
        end
    endtask

    initial begin
        logic [12:0] want;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow cycle %0d got no expected entry", cycle);
            end else begin
                want = exp_q.pop_front();
                check("outputs", {seg, an, dp, buzzer}, want);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; minutes = 7'd7; hours = 6'd0; alarm_trigger = 1'b0; alarm_ack = 1'b0;
        step(3);
        rst = 1'b0;
        step(FRAME);

        minutes = 7'd45; hours = 6'd9;
        step(2 * FRAME + 3);

        minutes = 7'd12; hours = 6'd17;
        step(FRAME + 6);
        minutes = 7'd13;
        step(2 * FRAME);

        minutes = 7'd63; hours = 6'd24;
        step(2 * FRAME);
        minutes = 7'd30; hours = 6'd6;
        step(FRAME);

        // Ring to timeout, stay matched, then drop and re-arm with a one-cycle ack.
        alarm_trigger = 1'b1;
        step(60);
        alarm_trigger = 1'b0;
        step(5);
        alarm_trigger = 1'b1;
        step(11);
        alarm_ack = 1'b1;
        step(1);
        alarm_ack = 1'b0;
        step(10);
        alarm_trigger = 1'b0;
        step(4);

        // Ack coinciding with the trigger edge is ignored in IDLE.
        alarm_trigger = 1'b1; alarm_ack = 1'b1;
        step(1);
        alarm_ack = 1'b0;
        step(20);
        alarm_ack = 1'b1;
        step(3);
        alarm_ack = 1'b0; alarm_trigger = 1'b0;
        step(4);

        // Reset mid-ring with the trigger still high must not re-ring.
        alarm_trigger = 1'b1;
        step(12);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2 * FRAME);
        alarm_trigger = 1'b0;
        step(3);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 5) begin
                minutes = 7'($urandom_range(0, 70));
                hours   = 6'($urandom_range(0, 30));
            end
            if ($urandom_range(0, 99) < 3) alarm_trigger = ~alarm_trigger;
            alarm_ack = ($urandom_range(0, 99) < 4);
            rst       = ($urandom_range(0, 999) < 3);
            step(1);
        end
        rst = 1'b0; alarm_ack = 1'b0;
        step(2);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
